// File: rtl/idli_pkg.sv
// Shared types for the idli serial datapath: ALU opcodes, nibble data and
// the accumulator's flag word and state encoding.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD = 2'd0,
    ALU_OP_AND = 2'd1,
    ALU_OP_OR  = 2'd2,
    ALU_OP_XOR = 2'd3
  } alu_op_t;

  // Packed MSB-first so {z,n,c,v} reads naturally as a nibble.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } acc_flags_t;

  localparam int ACC_FLAG_Z_IDX = 3;
  localparam int ACC_FLAG_N_IDX = 2;
  localparam int ACC_FLAG_C_IDX = 1;
  localparam int ACC_FLAG_V_IDX = 0;

  localparam int ACC_NIBBLES_DEFAULT = 4;

  typedef enum logic {
    ACC_ST_IDLE = 1'b0,
    ACC_ST_RUN  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/idli_alu_acc_m.sv
// Serial result accumulator: gathers ALU nibbles LSB-first, closes the
// carry loop back to the ALU and publishes the word with Z/N/C/V flags.
module idli_alu_acc_m
  import idli_pkg::*;
#(
  parameter int NIBBLES = ACC_NIBBLES_DEFAULT
) (
  input  logic                   i_acc_gck,
  input  logic                   i_acc_rst_n,
  input  logic                   i_acc_valid,
  input  logic                   i_acc_start,
  input  logic                   i_acc_flush,
  input  alu_op_t                i_acc_op,
  input  logic                   i_acc_cin_init,
  input  sqi_data_t              i_acc_data,
  input  logic                   i_acc_cout,
  input  logic                   i_acc_sign_cin,
  output logic                   o_acc_cin,
  output logic                   o_acc_busy,
  output logic                   o_acc_done,
  output logic [4*NIBBLES-1:0]   o_acc_result,
  output acc_flags_t             o_acc_flags
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(NIBBLES - 1);

  acc_state_t     state_q;
  logic [CW-1:0]  cnt_q;
  logic           carry_q;
  logic           zero_q;
  logic [W-1:0]   word_q;
  logic [W-1:0]   result_q;
  acc_flags_t     flags_q;
  logic           done_q;

  logic [CW-1:0]  pos;
  logic [W-1:0]   word_d;
  logic           zero_d;
  acc_flags_t     flags_d;
  logic           accept;
  logic           is_last;

  // A start always restarts at position 0, even mid-operation.
  assign accept = i_acc_valid & (i_acc_start | (state_q == ACC_ST_RUN));

  always_comb begin
    pos    = i_acc_start ? '0 : cnt_q;
    word_d = i_acc_start ? '0 : word_q;
    word_d[4*int'(pos) +: 4] = i_acc_data;
    zero_d  = (i_acc_start ? 1'b1 : zero_q) & (i_acc_data == 4'h0);
    is_last = (pos == LAST_POS);
    flags_d   = '0;
    flags_d.z = zero_d;
    flags_d.n = i_acc_data[3];
    if (i_acc_op == ALU_OP_ADD) begin
      flags_d.c = i_acc_cout;
      flags_d.v = i_acc_cout ^ i_acc_sign_cin;
    end
  end

  always_ff @(posedge i_acc_gck or negedge i_acc_rst_n) begin
    if (!i_acc_rst_n) begin
      state_q  <= ACC_ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      word_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_acc_flush) begin
        state_q <= ACC_ST_IDLE;
        cnt_q   <= '0;
        carry_q <= 1'b0;
      end else if (accept) begin
        carry_q <= i_acc_cout;
        word_q  <= word_d;
        zero_q  <= zero_d;
        if (is_last) begin
          state_q  <= ACC_ST_IDLE;
          cnt_q    <= '0;
          result_q <= word_d;
          flags_q  <= flags_d;
          done_q   <= 1'b1;
        end else begin
          state_q <= ACC_ST_RUN;
          cnt_q   <= pos + 1'b1;
        end
      end
    end
  end

  // Combinational so the ALU sees its carry-in in the same cycle.
  assign o_acc_cin    = i_acc_start ? i_acc_cin_init : carry_q;
  assign o_acc_busy   = (state_q == ACC_ST_RUN);
  assign o_acc_done   = done_q;
  assign o_acc_result = result_q;
  assign o_acc_flags  = flags_q;

endmodule
